// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment receiver.
// Holds the FSM state encoding, the active-low segment patterns
// (bit order a..g, index 0 = segment a) and the default settle length.
package seg7_pkg;

    // Receiver FSM states.
    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Default number of consecutive identical samples needed to lock.
    localparam int unsigned STABLE_CYCLES_DEF = 4;

    // Counter width that covers the whole legal STABLE_CYCLES range (2..15).
    localparam int unsigned STAB_CNT_W = 4;

    // Decimal digit patterns (active low, a..g).
    localparam logic [0:6] PAT_0 = 7'b0000001;
    localparam logic [0:6] PAT_1 = 7'b1001111;
    localparam logic [0:6] PAT_2 = 7'b0010010;
    localparam logic [0:6] PAT_3 = 7'b0000110;
    localparam logic [0:6] PAT_4 = 7'b1001100;
    localparam logic [0:6] PAT_5 = 7'b0100100;
    localparam logic [0:6] PAT_6 = 7'b0100000;
    localparam logic [0:6] PAT_7 = 7'b0001101;
    localparam logic [0:6] PAT_8 = 7'b0000000;
    localparam logic [0:6] PAT_9 = 7'b0000100;

    // Hex letter patterns, only legal when hex decoding is enabled.
    localparam logic [0:6] PAT_A = 7'b0001000;
    localparam logic [0:6] PAT_B = 7'b1100000;
    localparam logic [0:6] PAT_C = 7'b0110001;
    localparam logic [0:6] PAT_D = 7'b1000010;
    localparam logic [0:6] PAT_E = 7'b0110000;
    localparam logic [0:6] PAT_F = 7'b0111000;

    // All segments off.
    localparam logic [0:6] PAT_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_rx_if.sv
// seg7_rx_if: segment bus in, decoded status out.
// master = the side that drives the segment bus, slave = the receiver.
interface seg7_rx_if #(
    parameter int unsigned ERR_CNT_W = 8
);

    logic [0:6]           HEX_IN;
    logic [3:0]           DIGIT;
    logic                 VALID;
    logic                 BLANK;
    logic                 ERR;
    logic                 STROBE;
    logic [ERR_CNT_W-1:0] ERR_CNT;

    modport master (
        output HEX_IN,
        input  DIGIT,
        input  VALID,
        input  BLANK,
        input  ERR,
        input  STROBE,
        input  ERR_CNT
    );

    modport slave (
        input  HEX_IN,
        output DIGIT,
        output VALID,
        output BLANK,
        output ERR,
        output STROBE,
        output ERR_CNT
    );

endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: purely combinational segment-pattern lookup.
// Optional feature macro: SEG7_RX_HEX_EN -- when defined, the letters
// A b C d E F decode to 10..15; otherwise they are illegal patterns.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [0:6] i_pattern,
    output logic [3:0] o_value,
    output logic       o_legal,
    output logic       o_blank
);

    // Map a pattern to its value; anything not listed is illegal.
    always_comb begin
        o_value = '0;
        o_legal = 1'b0;
        o_blank = (i_pattern == PAT_BLANK);
        case (i_pattern)
            PAT_0: begin o_value = 4'd0; o_legal = 1'b1; end
            PAT_1: begin o_value = 4'd1; o_legal = 1'b1; end
            PAT_2: begin o_value = 4'd2; o_legal = 1'b1; end
            PAT_3: begin o_value = 4'd3; o_legal = 1'b1; end
            PAT_4: begin o_value = 4'd4; o_legal = 1'b1; end
            PAT_5: begin o_value = 4'd5; o_legal = 1'b1; end
            PAT_6: begin o_value = 4'd6; o_legal = 1'b1; end
            PAT_7: begin o_value = 4'd7; o_legal = 1'b1; end
            PAT_8: begin o_value = 4'd8; o_legal = 1'b1; end
            PAT_9: begin o_value = 4'd9; o_legal = 1'b1; end
`ifdef SEG7_RX_HEX_EN
            PAT_A: begin o_value = 4'd10; o_legal = 1'b1; end
            PAT_B: begin o_value = 4'd11; o_legal = 1'b1; end
            PAT_C: begin o_value = 4'd12; o_legal = 1'b1; end
            PAT_D: begin o_value = 4'd13; o_legal = 1'b1; end
            PAT_E: begin o_value = 4'd14; o_legal = 1'b1; end
            PAT_F: begin o_value = 4'd15; o_legal = 1'b1; end
`endif
            default: begin end
        endcase
    end

endmodule

// File: rtl/seg7_rx.sv
// seg7_rx: seven-segment display receiver. Registers the active-low
// segment bus, waits for it to stay stable, then reports the decoded
// digit, a blank display or an illegal pattern.
// Optional feature macro: SEG7_RX_HEX_EN (hex letters accepted as 10..15,
// handled inside seg7_pattern_decode).
module seg7_rx
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned ERR_CNT_W     = 8
) (
    input  logic     CLOCK_50,
    input  logic     RST,
    seg7_rx_if.slave bus
);

    localparam logic [STAB_CNT_W-1:0] LOCK_CNT = STAB_CNT_W'(STABLE_CYCLES - 1);

    logic [0:6]            r_sample;
    logic                  r_primed;
    state_t                r_state;
    logic [STAB_CNT_W-1:0] r_cnt;
    logic [3:0]            r_digit;
    logic                  r_valid;
    logic                  r_blank;
    logic                  r_err;
    logic                  r_strobe;
    logic                  r_have_legal;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    logic                  w_change;
    logic [3:0]            w_value;
    logic                  w_legal;
    logic                  w_blank;

    seg7_pattern_decode u_decode (
        .i_pattern (r_sample),
        .o_value   (w_value),
        .o_legal   (w_legal),
        .o_blank   (w_blank)
    );

    // The reset value of the sample register is not a captured sample, so
    // the first edge after reset always restarts the stability count.
    assign w_change = !r_primed || (bus.HEX_IN != r_sample);

    // Input register: every comparison works on the registered sample.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            r_sample <= PAT_BLANK;
        end else begin
            r_sample <= bus.HEX_IN;
        end
    end

    // Settle/lock FSM with all status outputs registered.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            r_primed     <= 1'b0;
            r_state      <= SETTLE;
            r_cnt        <= '0;
            r_digit      <= '0;
            r_valid      <= 1'b0;
            r_blank      <= 1'b0;
            r_err        <= 1'b0;
            r_strobe     <= 1'b0;
            r_have_legal <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_primed <= 1'b1;
            r_strobe <= 1'b0;
            if (w_change) begin
                r_state <= SETTLE;
                r_cnt   <= '0;
                r_valid <= 1'b0;
                r_blank <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    SETTLE: begin
                        if (r_cnt == LOCK_CNT) begin
                            r_state <= LOCKED;
                            if (w_legal) begin
                                r_valid      <= 1'b1;
                                r_digit      <= w_value;
                                r_strobe     <= !r_have_legal || (w_value != r_digit);
                                r_have_legal <= 1'b1;
                            end else if (w_blank) begin
                                r_blank      <= 1'b1;
                                r_have_legal <= 1'b0;
                            end else begin
                                r_err        <= 1'b1;
                                r_have_legal <= 1'b0;
                                if (r_err_cnt != '1) begin
                                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + STAB_CNT_W'(1);
                        end
                    end
                    LOCKED: begin
                        r_state <= LOCKED;
                    end
                    default: begin
                        r_state <= SETTLE;
                    end
                endcase
            end
        end
    end

    assign bus.DIGIT   = r_digit;
    assign bus.VALID   = r_valid;
    assign bus.BLANK   = r_blank;
    assign bus.ERR     = r_err;
    assign bus.STROBE  = r_strobe;
    assign bus.ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_seg7_rx.sv
// tb_seg7_rx: randomized scoreboard bench for seg7_rx. The reference model
// works on runs of identical samples: a run that lasts STABLE_CYCLES+1
// edges produces one lock event at run start + STABLE_CYCLES.
module tb_seg7_rx;

    localparam int unsigned SC = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned CNT_MAX = (1 << W) - 1;

`ifdef SEG7_RX_HEX_EN
    localparam int unsigned NLEG = 16;
`else
    localparam int unsigned NLEG = 10;
`endif

    typedef struct {
        int unsigned edge_n;
        logic [3:0]  digit;
        logic        valid;
        logic        blank;
        logic        err;
        logic        strobe;
        int unsigned cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seg7_rx_if #(.ERR_CNT_W(W)) bus ();

    seg7_rx #(.STABLE_CYCLES(SC), .ERR_CNT_W(W)) dut (
        .CLOCK_50 (clk),
        .RST      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int failures = 0;

    exp_t sbq[$];

    logic [0:6]  tbl [16];
    logic [0:6]  run_val;
    int unsigned run_start;
    bit          fresh;
    logic [3:0]  m_digit;
    bit          m_have;
    int unsigned m_cnt;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at edge %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        sbq.delete();
        fresh   = 1'b1;
        m_digit = '0;
        m_have  = 1'b0;
        m_cnt   = 0;
    endtask

    // Reference model: pattern p is the sample captured at edge e.
    task automatic model_edge(input logic [0:6] p, input int unsigned e);
        exp_t x;
        int   idx;
        if (fresh || p != run_val) begin
            run_val   = p;
            run_start = e;
            fresh     = 1'b0;
        end
        if (e - run_start == SC) begin
            idx = -1;
            for (int unsigned i = 0; i < NLEG; i++)
                if (tbl[4'(i)] == p) idx = int'(i);
            x.edge_n = e;
            x.valid = 1'b0; x.blank = 1'b0; x.err = 1'b0; x.strobe = 1'b0;
            if (idx >= 0) begin
                x.valid  = 1'b1;
                x.strobe = !m_have || (m_digit != 4'(idx));
                m_digit  = 4'(idx);
                m_have   = 1'b1;
            end else if (p == 7'b1111111) begin
                x.blank = 1'b1;
                m_have  = 1'b0;
            end else begin
                x.err  = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt++;
                m_have = 1'b0;
            end
            x.digit = m_digit;
            x.cnt   = m_cnt;
            sbq.push_back(x);
        end
    endtask

    // Called at a negedge; drives p for the next n rising edges.
    task automatic hold(input logic [0:6] p, input int unsigned n);
        repeat (n) begin
            bus.HEX_IN = p;
            model_edge(p, cyc + 1);
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_digit"},   bus.DIGIT,   0);
        chk({tag, "_valid"},   bus.VALID,   0);
        chk({tag, "_blank"},   bus.BLANK,   0);
        chk({tag, "_err"},     bus.ERR,     0);
        chk({tag, "_strobe"},  bus.STROBE,  0);
        chk({tag, "_err_cnt"}, bus.ERR_CNT, 0);
    endtask

    // Called at a negedge; asserts reset mid-cycle and releases on a negedge.
    task automatic do_reset(input logic [0:6] p, input int unsigned n);
        #1;
        rst = 1'b1;
        bus.HEX_IN = p;
        model_reset();
        #2;
        check_reset_outputs("reset");
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops an expectation whenever the DUT enters a locked state.
    bit prev_lock = 1'b0;
    always @(negedge clk) begin
        bit lk;
        bit rise;
        exp_t x;
        if (rst) begin
            prev_lock = 1'b0;
        end else begin
            lk   = bus.VALID || bus.BLANK || bus.ERR;
            rise = lk && !prev_lock;
            chk("exclusive_flags", int'(bus.VALID) + int'(bus.BLANK) + int'(bus.ERR) <= 1, 1);
            chk("strobe_only_at_lock", bus.STROBE && !rise, 0);
            if (rise) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_lock: got lock at edge %0d, expected none", cyc);
                end else begin
                    x = sbq.pop_front();
                    chk("lock_edge", cyc,         x.edge_n);
                    chk("digit",     bus.DIGIT,   x.digit);
                    chk("valid",     bus.VALID,   x.valid);
                    chk("blank",     bus.BLANK,   x.blank);
                    chk("err",       bus.ERR,     x.err);
                    chk("strobe",    bus.STROBE,  x.strobe);
                    chk("err_cnt",   bus.ERR_CNT, x.cnt);
                end
            end else if (sbq.size() > 0 && sbq[0].edge_n == cyc) begin
                x = sbq.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_lock: got no lock at edge %0d, expected lock", cyc);
            end
            prev_lock = lk;
        end
    end

    initial begin
        logic [0:6] p;
        logic [0:6] last_p;
        int unsigned r;

        tbl[0]  = 7'b0000001; tbl[1]  = 7'b1001111; tbl[2]  = 7'b0010010;
        tbl[3]  = 7'b0000110; tbl[4]  = 7'b1001100; tbl[5]  = 7'b0100100;
        tbl[6]  = 7'b0100000; tbl[7]  = 7'b0001101; tbl[8]  = 7'b0000000;
        tbl[9]  = 7'b0000100; tbl[10] = 7'b0001000; tbl[11] = 7'b1100000;
        tbl[12] = 7'b0110001; tbl[13] = 7'b1000010; tbl[14] = 7'b0110000;
        tbl[15] = 7'b0111000;

        bus.HEX_IN = 7'b1111111;
        model_reset();
        #1 rst = 1'b1;
        #2 check_reset_outputs("init");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Blank held from reset, then digit 2, then a short glitch.
        hold(7'b1111111, 8);
        hold(7'b0010010, 10);
        hold(7'b1111110, 2);
        hold(7'b0010010, 8);

        // Letter A: illegal by default, digit 10 with hex enabled.
        hold(7'b0001000, 8);

        // Reset while settling on 6, then 6 again.
        hold(7'b0100000, 2);
        do_reset(7'b0100000, 2);
        hold(7'b0100000, 8);

        // Randomized segments with occasional resets.
        last_p = 7'b0100000;
        for (int unsigned k = 0; k < 150; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      p = tbl[4'($urandom_range(0, 15))];
            else if (r == 6) p = 7'b1111111;
            else if (r <= 8) p = 7'($urandom);
            else             p = last_p;
            hold(p, $urandom_range(1, 9));
            last_p = p;
            if ($urandom_range(0, 39) == 0) do_reset(p, $urandom_range(1, 3));
        end

        // Saturation: alternate two illegal patterns.
        for (int unsigned k = 0; k < 300; k++) begin
            hold(7'b1111110, 6);
            hold(7'b0111111, 6);
        end
        hold(7'b1111110, 2);

        chk("queue_drained", sbq.size(), 0);
        chk("err_cnt_saturated", bus.ERR_CNT, CNT_MAX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_rx.md
SEG7_RX -- requirements
Module: seg7_rx

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before a pattern is accepted; legal range 2..15.
REQ-002 SHALL have parameter ERR_CNT_W, default 8, meaning width of the saturating error counter.
REQ-003 CLOCK_50  input  1  single clock; all state on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 HEX_IN  input  [0:6]  active-low segment bus; index 0 = segment a, index 6 = segment g.
REQ-006 DIGIT  output  4  last accepted legal value.
REQ-007 VALID  output  1  level; locked on a legal digit pattern.
REQ-008 BLANK  output  1  level; locked on 7'b1111111.
REQ-009 ERR  output  1  level; locked on an illegal pattern.
REQ-010 STROBE  output  1  one-cycle pulse per new accepted legal value.
REQ-011 ERR_CNT  output  ERR_CNT_W  count of illegal-pattern lock events.

Function
REQ-012 HEX_IN SHALL pass through one input register (sample) before any comparison.
REQ-013 Legal patterns SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001101, 8=0000000, 9=0000100.
REQ-014 FSM states SHALL be SETTLE, LOCKED; SETTLE->LOCKED when the sample has equalled its previous value for STABLE_CYCLES consecutive edges; LOCKED->SETTLE on any sample change.
REQ-015 Any sample change SHALL clear the stability counter to 0 in the same edge, including mid-count in SETTLE.
REQ-016 Latency: a new pattern first captured by the sample register at edge N, held steady, SHALL update outputs at edge N+STABLE_CYCLES.
REQ-017 In SETTLE, VALID, BLANK, ERR SHALL be 0 and DIGIT SHALL hold its last value.
REQ-018 On lock: legal -> VALID=1, DIGIT=decoded value; 1111111 -> BLANK=1, DIGIT unchanged; otherwise ERR=1, DIGIT unchanged, ERR_CNT += 1.
REQ-019 STROBE SHALL pulse for exactly one cycle on a legal lock when the decoded value differs from DIGIT or when no legal lock has occurred since reset or since the last ERR/BLANK lock.
REQ-020 Re-locking on an identical legal value after a glitch shorter than STABLE_CYCLES SHALL NOT pulse STROBE.
REQ-021 ERR_CNT SHALL saturate at all-ones and never wrap.
REQ-022 VALID, BLANK, ERR SHALL be mutually exclusive at all times.

Reset
REQ-023 Reset SHALL force: sample=7'b1111111, state=SETTLE, counter=0, DIGIT=0, VALID=0, BLANK=0, ERR=0, STROBE=0, ERR_CNT=0.
REQ-024 Reset asserted mid-settle or mid-pulse SHALL abort immediately; no STROBE SHALL appear on the first edge after release.

Configuration
REQ-025 Macro SEG7_RX_HEX_EN defined: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000 SHALL decode to 10..15 as legal.
REQ-026 Macro SEG7_RX_HEX_EN undefined: those six patterns SHALL be treated as illegal (ERR path).

Structure
REQ-027 Package seg7_pkg SHALL hold the state encoding, the 16 pattern constants, the BLANK constant and the STABLE_CYCLES default.
REQ-028 Combinational lookup SHALL live in sub-module seg7_pattern_decode (pattern in; value, legal, blank out); seg7_rx holds all sequential logic.

Verification
REQ-029 Reset then HEX_IN=1111111 held -> BLANK=1 at edge STABLE_CYCLES+1 after release, STROBE never pulses, ERR_CNT=0.
REQ-030 HEX_IN=0010010 held 10 cycles (STABLE_CYCLES=4) -> DIGIT=2, VALID=1 exactly 4 edges after capture, STROBE one cycle.
REQ-031 DIGIT=2 locked, HEX_IN=1111110 for 2 cycles then back to 0010010 -> VALID drops during settle, relocks DIGIT=2, no STROBE, ERR_CNT unchanged.
REQ-032 HEX_IN=0001000 held: without SEG7_RX_HEX_EN -> ERR=1, ERR_CNT=1; with it -> DIGIT=10, VALID=1, STROBE.
REQ-033 Alternate two illegal patterns, each held 6 cycles, 300 times -> ERR_CNT=255, saturated.
REQ-034 RST pulsed while settling on 0100000 -> all outputs reset value immediately; after release 0100000 locks as DIGIT=6 with STROBE.
